ghost_mode_sched: RTL and testbench
===================================

# ghost_mode_sched

Global ghost-mode scheduler that sequences the per-level scatter/chase timetable and frightened intervals. All ghost movers (Blinky and the other ghosts) read its registered `isScatter`/`isChase`/`isFrightened` mode lines and its one-cycle `reverse` pulse. It sits between the game FSM, which supplies `level_start`, `pellet_eaten` and `freeze`, and the ghost modules. All timing is counted in `frame_tick` units.

## Interface
- `SCATTER_LONG`, default 420: frames in scatter phases 0 and 2.
- `SCATTER_SHORT`, default 300: frames in scatter phases 4 and 6.
- `CHASE_LEN`, default 1200: frames in chase phases 1, 3 and 5.
- `FRIGHT_LEN`, default 360: frames per frightened interval.
- `FLASH_LEN`, default 120: final frightened frames during which `fright_flash` is high (must be ≤ `FRIGHT_LEN`).
- `TIMER_W`, default 11: width of both down-counters. All durations are nonzero and fit in `TIMER_W`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `level_start` in 1: pulse; restarts the timetable at phase 0.
- `pellet_eaten` in 1: pulse; a power pellet was eaten.
- `freeze` in 1: level; suspends all tick counting (death and intermission).
- `isScatter` out 1: scatter mode active.
- `isChase` out 1: chase mode active.
- `isFrightened` out 1: frightened mode active.
- `fright_flash` out 1: frightened interval is ending.
- `reverse` out 1: one-cycle pulse; ghosts must reverse direction.
- `phase` out 3: current timetable phase, 0..7.

## Operation
- **States.** IDLE, RUN, FRIGHT. Each has a `phase_timer` and a `fright_timer`, each `TIMER_W` bits and holding frames remaining.
- **Timetable.** Even phases are scatter, odd phases are chase. Durations by phase:
  - phases 0 and 2: `SCATTER_LONG`
  - phases 4 and 6: `SCATTER_SHORT`
  - phases 1, 3 and 5: `CHASE_LEN`
  - phase 7: chase, indefinite (timer not decremented, phase never advances).
- **Counting ticks.** A tick counts only when `frame_tick` is 1 and `freeze` is 0.
- **IDLE.** All mode outputs are 0 and `pellet_eaten` is ignored. `level_start` moves to RUN with `phase`=0, `phase_timer`=`SCATTER_LONG` and `fright_timer`=0. No `reverse` is issued.
- **RUN.**
  - `isScatter`=~`phase[0]`, `isChase`=`phase[0]`, `isFrightened`=0.
  - On a counted tick in phases 0..6: if `phase_timer`==1, advance `phase`, load the next duration and pulse `reverse`; otherwise decrement.
- **Entering FRIGHT.** `pellet_eaten` in RUN moves to FRIGHT, loads `fright_timer`=`FRIGHT_LEN` and pulses `reverse`. `phase_timer` and `phase` are frozen.
- **FRIGHT.**
  - `isFrightened`=1, `isScatter`=`isChase`=0, `phase` holds its value.
  - `fright_flash`=1 while `fright_timer` ≤ `FLASH_LEN`.
  - On a counted tick: if `fright_timer`==1, return to RUN with the same `phase` and remaining `phase_timer`, and no `reverse`. Otherwise decrement.
  - `pellet_eaten` in FRIGHT reloads `FRIGHT_LEN` and pulses `reverse`.
- **Event priority within one cycle**, highest first:
  1. `level_start`: from any state, goes to RUN phase 0 and discards frightened.
  2. `pellet_eaten`: the concurrent tick is not applied to either timer.
  3. Counted tick.
- **Freeze.** During `freeze`, `level_start` and `pellet_eaten` still act; only tick counting is suspended.

## Timing
- **Reset values.** `isScatter`=0, `isChase`=0, `isFrightened`=0, `fright_flash`=0, `reverse`=0, `phase`=0, both timers 0, state IDLE.
- **Registered outputs.** All outputs are registered. Their effects appear on the first rising edge after the triggering input is sampled (1-cycle latency).
- **Phase lengths.** Phase n lasts exactly its duration in counted ticks: the phase change occurs on the edge that samples the Nth counted tick.
- **`reverse` pulse.** High for exactly one `clk` cycle per event and never stretched. Two events on consecutive cycles give two pulses.
- **Frightened length.** Lasts exactly `FRIGHT_LEN` counted ticks after the last `pellet_eaten`. `fright_flash` rises on the edge where `fright_timer` becomes `FLASH_LEN`.
- **Reset mid-operation.** Asserting `reset` at any time returns immediately (asynchronously) to the reset values above.

## Test plan
Parameters for all scenarios: `SCATTER_LONG`=4, `SCATTER_SHORT`=3, `CHASE_LEN`=6, `FRIGHT_LEN`=5, `FLASH_LEN`=2.

- **Start.** Reset, then `level_start` → `isScatter`=1, `phase`=0, no `reverse`. After 4 ticks → `phase`=1, `isChase`=1, one `reverse` pulse.
- **Full timetable.** 4+6+4+6+3+6+3 = 32 ticks → `phase`=7, `isChase`=1, 7 `reverse` pulses. 100 more ticks → `phase` stays 7 with no further pulses.
- **Frightened interval.** `pellet_eaten` after 2 ticks of phase 0 → `isFrightened`=1 plus a `reverse` pulse; `fright_flash` rises after 3 ticks. After 5 ticks → `isScatter`=1 with no `reverse`, and phase 0 ends 2 ticks later.
- **Re-eat and simultaneous tick.** `pellet_eaten` on the same cycle as the expiring fright tick → stays frightened for 5 more ticks and `reverse` pulses. `pellet_eaten` on the same cycle as a RUN tick → `phase_timer` is not decremented.
- **Freeze.** Hold `freeze`=1 across 10 ticks → timers unchanged. `pellet_eaten` during `freeze` → still enters FRIGHT.
- **Restart and reset.** `level_start` in FRIGHT at `phase`=3 → `phase`=0, `isScatter`=1, `isFrightened`=0. Asserting `reset` mid-FRIGHT → all outputs 0 immediately, and `pellet_eaten` is then ignored in IDLE.

Source files
------------

// File: rtl/ghost_mode_sched_if.sv
// Mode-line bundle between the game FSM and the ghost-mode scheduler.
// The game side drives the event inputs. The scheduler drives the mode lines that the ghost movers read.
interface ghost_mode_sched_if;
  logic       frame_tick;
  logic       level_start;
  logic       pellet_eaten;
  logic       freeze;
  logic       isScatter;
  logic       isChase;
  logic       isFrightened;
  logic       fright_flash;
  logic       reverse;
  logic [2:0] phase;

  modport master (
    output frame_tick, level_start, pellet_eaten, freeze,
    input  isScatter, isChase, isFrightened, fright_flash, reverse, phase
  );

  modport slave (
    input  frame_tick, level_start, pellet_eaten, freeze,
    output isScatter, isChase, isFrightened, fright_flash, reverse, phase
  );
endinterface

// File: rtl/ghost_mode_sched.sv
// Global ghost-mode scheduler: runs the scatter/chase timetable and the frightened intervals.
// It issues registered mode lines and a one-cycle reverse pulse.
module ghost_mode_sched #(
  parameter int SCATTER_LONG  = 420,
  parameter int SCATTER_SHORT = 300,
  parameter int CHASE_LEN     = 1200,
  parameter int FRIGHT_LEN    = 360,
  parameter int FLASH_LEN     = 120,
  parameter int TIMER_W       = 11
) (
  input  logic               clk,
  input  logic               reset,
  ghost_mode_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FRIGHT = 2'd2
  } state_t;

  state_t               state_r;
  state_t               stateNext_s;
  logic [2:0]           phase_r;
  logic [2:0]           phaseNext_s;
  logic [TIMER_W-1:0]   phaseTimer_r;
  logic [TIMER_W-1:0]   phaseTimerNext_s;
  logic [TIMER_W-1:0]   frightTimer_r;
  logic [TIMER_W-1:0]   frightTimerNext_s;
  logic                 tickCounted_s;
  logic                 reverseNext_s;
  logic                 scatterNext_s;
  logic                 chaseNext_s;
  logic                 frightNext_s;
  logic                 flashNext_s;

  // Phase 7 is the endless chase, so its timer load is never consumed.
  function automatic logic [TIMER_W-1:0] phaseDuration(input logic [2:0] ph);
    logic [TIMER_W-1:0] dur;
    case (ph)
      3'd0, 3'd2:       dur = TIMER_W'(SCATTER_LONG);
      3'd4, 3'd6:       dur = TIMER_W'(SCATTER_SHORT);
      3'd1, 3'd3, 3'd5: dur = TIMER_W'(CHASE_LEN);
      default:          dur = {TIMER_W{1'b0}};
    endcase
    return dur;
  endfunction

  assign tickCounted_s = bus.frame_tick & ~bus.freeze;
  assign bus.phase     = phase_r;

  // Next-state, timer and pulse logic; level_start outranks pellet_eaten, which outranks the tick.
  always_comb begin
    stateNext_s       = state_r;
    phaseNext_s       = phase_r;
    phaseTimerNext_s  = phaseTimer_r;
    frightTimerNext_s = frightTimer_r;
    reverseNext_s     = 1'b0;

    if (bus.level_start) begin
      stateNext_s       = RUN;
      phaseNext_s       = 3'd0;
      phaseTimerNext_s  = TIMER_W'(SCATTER_LONG);
      frightTimerNext_s = {TIMER_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          stateNext_s = IDLE;
        end
        RUN: begin
          if (bus.pellet_eaten) begin
            stateNext_s       = FRIGHT;
            frightTimerNext_s = TIMER_W'(FRIGHT_LEN);
            reverseNext_s     = 1'b1;
          end else if (tickCounted_s && (phase_r != 3'd7)) begin
            if (phaseTimer_r == TIMER_W'(1)) begin
              phaseNext_s      = phase_r + 3'd1;
              phaseTimerNext_s = phaseDuration(phase_r + 3'd1);
              reverseNext_s    = 1'b1;
            end else begin
              phaseTimerNext_s = phaseTimer_r - TIMER_W'(1);
            end
          end else begin
            phaseTimerNext_s = phaseTimer_r;
          end
        end
        FRIGHT: begin
          // The suspended phase and its timer resume untouched on exit, with no reverse.
          if (bus.pellet_eaten) begin
            frightTimerNext_s = TIMER_W'(FRIGHT_LEN);
            reverseNext_s     = 1'b1;
          end else if (tickCounted_s) begin
            if (frightTimer_r == TIMER_W'(1)) begin
              stateNext_s       = RUN;
              frightTimerNext_s = {TIMER_W{1'b0}};
            end else begin
              frightTimerNext_s = frightTimer_r - TIMER_W'(1);
            end
          end else begin
            frightTimerNext_s = frightTimer_r;
          end
        end
        default: begin
          stateNext_s       = IDLE;
          phaseNext_s       = 3'd0;
          phaseTimerNext_s  = {TIMER_W{1'b0}};
          frightTimerNext_s = {TIMER_W{1'b0}};
        end
      endcase
    end

    scatterNext_s = (stateNext_s == RUN) && !phaseNext_s[0];
    chaseNext_s   = (stateNext_s == RUN) && phaseNext_s[0];
    frightNext_s  = (stateNext_s == FRIGHT);
    flashNext_s   = (stateNext_s == FRIGHT) && (frightTimerNext_s <= TIMER_W'(FLASH_LEN));
  end

  // State, timers and registered mode lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r          <= IDLE;
      phase_r          <= 3'd0;
      phaseTimer_r     <= {TIMER_W{1'b0}};
      frightTimer_r    <= {TIMER_W{1'b0}};
      bus.isScatter    <= 1'b0;
      bus.isChase      <= 1'b0;
      bus.isFrightened <= 1'b0;
      bus.fright_flash <= 1'b0;
      bus.reverse      <= 1'b0;
    end else begin
      state_r          <= stateNext_s;
      phase_r          <= phaseNext_s;
      phaseTimer_r     <= phaseTimerNext_s;
      frightTimer_r    <= frightTimerNext_s;
      bus.isScatter    <= scatterNext_s;
      bus.isChase      <= chaseNext_s;
      bus.isFrightened <= frightNext_s;
      bus.fright_flash <= flashNext_s;
      bus.reverse      <= reverseNext_s;
    end
  end

endmodule

// File: tb/tb_ghost_mode_sched.sv
// Self-checking bench for ghost_mode_sched.
// An elapsed-count model is compared with the outputs every cycle, and directed literal checks follow each scenario.
module tb_ghost_mode_sched;
  localparam int SL = 4, SS = 3, CL = 6, FLEN = 5, FLASH = 2, TW = 11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  ghost_mode_sched_if bus();

  ghost_mode_sched #(
    .SCATTER_LONG(SL), .SCATTER_SHORT(SS), .CHASE_LEN(CL),
    .FRIGHT_LEN(FLEN), .FLASH_LEN(FLASH), .TIMER_W(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int revCount = 0;
  int base;

  // Model: mode 0 idle, 1 run, 2 frightened; elapsed counters count up toward each duration.
  int dur [8] = '{SL, CL, SL, CL, SS, CL, SS, 0};
  int mMode = 0, mPhase = 0, mPhEl = 0, mFrEl = 0;
  bit mRev = 1'b0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      mMode = 0; mPhase = 0; mPhEl = 0; mFrEl = 0; mRev = 1'b0;
    end else begin
      mRev = 1'b0;
      if (bus.level_start) begin
        mMode = 1; mPhase = 0; mPhEl = 0; mFrEl = 0;
      end else if (mMode == 1) begin
        if (bus.pellet_eaten) begin
          mMode = 2; mFrEl = 0; mRev = 1'b1;
        end else if (bus.frame_tick && !bus.freeze && mPhase < 7) begin
          mPhEl++;
          if (mPhEl == dur[mPhase]) begin
            mPhase++; mPhEl = 0; mRev = 1'b1;
          end
        end
      end else if (mMode == 2) begin
        if (bus.pellet_eaten) begin
          mFrEl = 0; mRev = 1'b1;
        end else if (bus.frame_tick && !bus.freeze) begin
          mFrEl++;
          if (mFrEl == FLEN) mMode = 1;
        end
      end
    end
  end

  // Cycle compare on the falling edge, away from the active edge.
  initial forever begin
    logic [7:0] expV, actV;
    @(negedge clk);
    expV = {mMode == 1 && (mPhase % 2) == 0, mMode == 1 && (mPhase % 2) == 1, mMode == 2,
            mMode == 2 && (FLEN - mFrEl) <= FLASH, mRev, 3'(mPhase)};
    actV = {bus.isScatter, bus.isChase, bus.isFrightened, bus.fright_flash, bus.reverse, bus.phase};
    tests++;
    if (actV !== expV) begin
      fails++;
      $display("FAIL cycle_compare t=%0t got=%b want=%b (scat,chase,fri,flash,rev,phase)", $time, actV, expV);
    end
    if (bus.reverse === 1'b1) revCount++;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit ft, input bit ls, input bit pe);
    bus.frame_tick = ft; bus.level_start = ls; bus.pellet_eaten = pe;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0; bus.level_start = 1'b0; bus.pellet_eaten = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  function automatic int allOut();
    return int'({bus.isScatter, bus.isChase, bus.isFrightened, bus.fright_flash, bus.reverse, bus.phase});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_tick = 1'b0; bus.level_start = 1'b0; bus.pellet_eaten = 1'b0; bus.freeze = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", allOut(), 0);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // Start
    cyc(1'b0, 1'b1, 1'b0);
    chk("start_scatter", bus.isScatter, 1);
    chk("start_phase", bus.phase, 0);
    chk("start_no_reverse", bus.reverse, 0);
    tick(3);
    chk("phase0_holds", bus.phase, 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("phase1_after_4", bus.phase, 1);
    chk("phase1_chase", bus.isChase, 1);
    chk("phase1_reverse", bus.reverse, 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("reverse_one_cycle", bus.reverse, 0);

    // Full timetable
    cyc(1'b0, 1'b1, 1'b0);
    base = revCount;
    tick(32);
    chk("timetable_phase7", bus.phase, 7);
    chk("timetable_chase", bus.isChase, 1);
    chk("timetable_reverses", revCount - base, 7);
    base = revCount;
    tick(100);
    chk("phase7_stays", bus.phase, 7);
    chk("phase7_no_reverse", revCount - base, 0);

    // Frightened interval
    cyc(1'b0, 1'b1, 1'b0);
    tick(2);
    cyc(1'b0, 1'b0, 1'b1);
    chk("fright_enter", bus.isFrightened, 1);
    chk("fright_reverse", bus.reverse, 1);
    chk("fright_no_scatter", bus.isScatter, 0);
    cyc(1'b0, 1'b0, 1'b0);
    base = revCount;
    tick(2);
    chk("flash_low_2", bus.fright_flash, 0);
    tick(1);
    chk("flash_high_3", bus.fright_flash, 1);
    tick(2);
    chk("fright_exit_scatter", bus.isScatter, 1);
    chk("fright_exit_no_reverse", revCount - base, 0);
    tick(1);
    chk("resume_phase0", bus.phase, 0);
    tick(1);
    chk("resume_phase1", bus.phase, 1);

    // Re-eat on the expiring tick, then pellet with a RUN tick
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    tick(4);
    cyc(1'b1, 1'b0, 1'b1);
    chk("reeat_stays_fright", bus.isFrightened, 1);
    chk("reeat_reverse", bus.reverse, 1);
    cyc(1'b0, 1'b0, 1'b0);
    tick(4);
    chk("reeat_still_fright", bus.isFrightened, 1);
    tick(1);
    chk("reeat_exit_scatter", bus.isScatter, 1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("run_tick_pellet_fright", bus.isFrightened, 1);
    cyc(1'b0, 1'b0, 1'b0);
    tick(5);
    tick(3);
    chk("timer_not_decremented", bus.phase, 0);
    tick(1);
    chk("phase1_after_full4", bus.phase, 1);

    // Freeze
    cyc(1'b0, 1'b1, 1'b0);
    tick(1);
    bus.freeze = 1'b1;
    tick(10);
    chk("freeze_phase_held", bus.phase, 0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("freeze_pellet_fright", bus.isFrightened, 1);
    tick(10);
    chk("freeze_fright_held", bus.isFrightened, 1);
    chk("freeze_no_flash", bus.fright_flash, 0);
    bus.freeze = 1'b0;
    tick(4);
    chk("unfreeze_flash", bus.fright_flash, 1);
    tick(1);
    chk("unfreeze_exit", bus.isScatter, 1);
    tick(2);
    chk("freeze_phase0_left", bus.phase, 0);
    tick(1);
    chk("freeze_phase1", bus.phase, 1);

    // Restart and reset
    cyc(1'b0, 1'b1, 1'b0);
    tick(14);
    chk("restart_phase3", bus.phase, 3);
    cyc(1'b0, 1'b0, 1'b1);
    chk("restart_fright", bus.isFrightened, 1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("restart_phase0", bus.phase, 0);
    chk("restart_scatter", bus.isScatter, 1);
    chk("restart_not_fright", bus.isFrightened, 0);
    chk("restart_no_reverse", bus.reverse, 0);
    cyc(1'b0, 1'b0, 1'b1);
    tick(1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", allOut(), 0);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    chk("idle_ignores_pellet", allOut(), 0);
    tick(3);
    chk("idle_ignores_ticks", allOut(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
